// File: rtl/prim_fifo_pkg.sv
// Shared sizing helper and status bundle for the prim_fifo family (sync, async, multi-channel).
package prim_fifo_pkg;

  // Upper bound on the depth field of the status bundle; any single FIFO uses the low DepthW bits.
  localparam int StatusDepthW = 16;

  // Width needed to hold an occupancy of 0..depth; a zero-depth FIFO still gets a 1-bit field.
  function automatic int fifo_cnt_w(input int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                    full;
    logic                    almost_full;
    logic                    almost_empty;
    logic [StatusDepthW-1:0] depth;
  } fifo_status_t;

endpackage

// File: rtl/prim_fifo_ptr.sv
// Wrapping pointer 0..Depth-1 with synchronous reset, flush and increment.
module prim_fifo_ptr #(
  parameter int Depth = 4,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            incr_i,
  output logic [PtrW-1:0] ptr_o
);

  localparam logic [PtrW-1:0] Last = PtrW'(Depth - 1);

  // Explicit wrap at Depth-1 keeps non-power-of-2 depths exact.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      ptr_o <= '0;
    end else if (incr_i) begin
      ptr_o <= (ptr_o == Last) ? '0 : ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// Synchronous valid/ready FIFO with watermarks, occupancy and peak monitor; any Depth incl. 0.
// Pass=1 gives zero-latency bypass when empty; full FIFO never accepts a write even while being read.
module prim_fifo_sync_wm
  import prim_fifo_pkg::*;
#(
  parameter int  Width             = 16,
  parameter int  Depth             = 4,
  parameter bit  Pass              = 1'b1,
  parameter bit  OutputZeroIfEmpty = 1'b1,
  localparam int DepthW            = fifo_cnt_w(Depth)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  input  logic [DepthW-1:0] af_thresh_i,
  input  logic [DepthW-1:0] ae_thresh_i,
  output logic              full_o,
  output logic [DepthW-1:0] depth_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [DepthW-1:0] peak_o
);

  if (Depth == 0) begin : g_wire
    logic unused_wire;
    assign unused_wire    = ^{clk_i, rst_i, clr_i, ae_thresh_i};

    assign wready_o       = rready_i;
    assign rvalid_o       = wvalid_i;
    assign rdata_o        = (OutputZeroIfEmpty && !wvalid_i) ? '0 : wdata_i;
    assign full_o         = 1'b1;
    assign depth_o        = '0;
    assign peak_o         = '0;
    assign almost_empty_o = 1'b1;
    assign almost_full_o  = (af_thresh_i == '0);

  end else begin : g_fifo
    logic [DepthW-1:0] count_q, count_d, peak_q;
    logic              init_q;
    logic              gate, empty, full;
    logic              push, pop, bypass, store_wr, rd_adv;
    logic [Width-1:0]  mem_rdata, rdata_raw;
    fifo_status_t      status;
    logic              unused_status;

    // Reset, the post-reset init cycle and a flush all block both handshakes.
    assign gate     = rst_i | init_q | clr_i;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DepthW'(Depth));

    assign wready_o = ~full & ~gate;
    assign rvalid_o = (~empty | (Pass & wvalid_i)) & ~gate;

    assign push     = wvalid_i & wready_o;
    assign pop      = rvalid_o & rready_i;
    // A pop while empty can only be the bypassed write itself; it never touches storage.
    assign bypass   = Pass & empty & pop;
    assign store_wr = push & ~bypass;
    assign rd_adv   = pop & ~bypass;

    always_comb begin
      count_d = count_q;
      if (store_wr && !rd_adv) begin
        count_d = count_q + 1'b1;
      end else if (rd_adv && !store_wr) begin
        count_d = count_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        count_q <= '0;
        peak_q  <= '0;
        init_q  <= 1'b1;
      end else begin
        init_q <= 1'b0;
        if (clr_i) begin
          count_q <= '0;
          peak_q  <= '0;
        end else begin
          count_q <= count_d;
          if (count_d > peak_q) begin
            peak_q <= count_d;
          end
        end
      end
    end

    if (Depth == 1) begin : g_single
      logic [Width-1:0] mem_q;

      always_ff @(posedge clk_i) begin
        if (store_wr) begin
          mem_q <= wdata_i;
        end
      end

      assign mem_rdata = mem_q;

    end else begin : g_multi
      localparam int PtrW = $clog2(Depth);

      logic [PtrW-1:0]  wptr, rptr;
      logic [Width-1:0] mem_q [Depth];

      prim_fifo_ptr #(.Depth(Depth)) u_wptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .incr_i (store_wr),
        .ptr_o  (wptr)
      );

      prim_fifo_ptr #(.Depth(Depth)) u_rptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i),
        .incr_i (rd_adv),
        .ptr_o  (rptr)
      );

      always_ff @(posedge clk_i) begin
        if (store_wr) begin
          mem_q[wptr] <= wdata_i;
        end
      end

      assign mem_rdata = mem_q[rptr];
    end

    assign rdata_raw = (Pass && empty) ? wdata_i : mem_rdata;
    assign rdata_o   = (OutputZeroIfEmpty && !rvalid_o) ? '0 : rdata_raw;

    assign status.full         = full;
    assign status.almost_full  = (count_q >= af_thresh_i);
    assign status.almost_empty = (count_q <= ae_thresh_i);
    assign status.depth        = StatusDepthW'(count_q);
    assign unused_status       = ^status.depth[StatusDepthW-1:DepthW];

    assign full_o         = status.full;
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;
    assign depth_o        = status.depth[DepthW-1:0];
    assign peak_o         = peak_q;
  end

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Several FIFO builds driven side by side and checked every cycle against a queue-level reference model.
module tb_prim_fifo_sync_wm;
  import prim_fifo_pkg::*;

  localparam int NI = 7;
  // 0:D4 pass  1:D5  2:D8  3:D0  4:D1  5:D4 no-pass  6:D3
  localparam int DEP [NI] = '{4, 5, 8, 0, 1, 4, 3};
  localparam bit PAS [NI] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  logic          clk;
  logic          rst;
  logic [NI-1:0] clr, wvalid, rready;
  logic [15:0]   wdata [NI];
  logic [3:0]    af_th [NI];
  logic [3:0]    ae_th [NI];
  logic [NI-1:0] wready_v, rvalid_v, full_v, af_v, ae_v;
  logic [15:0]   rdata_a [NI];
  logic [3:0]    depth_a [NI];
  logic [3:0]    peak_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = fifo_cnt_w(DEP[g]);
    logic [W-1:0] dep_w, pk_w;

    prim_fifo_sync_wm #(
      .Width(16), .Depth(DEP[g]), .Pass(PAS[g]), .OutputZeroIfEmpty(1'b1)
    ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clr_i          (clr[g]),
      .wvalid_i       (wvalid[g]),
      .wready_o       (wready_v[g]),
      .wdata_i        (wdata[g]),
      .rvalid_o       (rvalid_v[g]),
      .rready_i       (rready[g]),
      .rdata_o        (rdata_a[g]),
      .af_thresh_i    (af_th[g][W-1:0]),
      .ae_thresh_i    (ae_th[g][W-1:0]),
      .full_o         (full_v[g]),
      .depth_o        (dep_w),
      .almost_full_o  (af_v[g]),
      .almost_empty_o (ae_v[g]),
      .peak_o         (pk_w)
    );

    assign depth_a[g] = 4'(dep_w);
    assign peak_a[g]  = 4'(pk_w);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per-instance circular list of held words plus init flag and peak.
  bit          m_init [NI];
  int          m_cnt  [NI];
  int          m_hd   [NI];
  int          m_pk   [NI];
  logic [15:0] m_dat  [NI][64];
  bit          e_wr   [NI];
  bit          e_rv   [NI];
  int          n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(input string s, input int i);
    return $sformatf("%s[%0d]", s, i);
  endfunction

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int          d, wm, af, ae;
      bit          gate;
      logic [15:0] erd;
      d  = DEP[i];
      wm = (1 << fifo_cnt_w(d)) - 1;
      af = int'(af_th[i]) & wm;
      ae = int'(ae_th[i]) & wm;
      if (d == 0) begin
        e_wr[i] = rready[i];
        e_rv[i] = wvalid[i];
        chk(tg("wready", i), wready_v[i], rready[i]);
        chk(tg("rvalid", i), rvalid_v[i], wvalid[i]);
        if (wvalid[i]) chk(tg("rdata", i), rdata_a[i], wdata[i]);
        chk(tg("full", i), full_v[i], 1);
        chk(tg("depth", i), depth_a[i], 0);
        chk(tg("peak", i), peak_a[i], 0);
        chk(tg("aempty", i), ae_v[i], 1);
        chk(tg("afull", i), af_v[i], (af == 0));
      end else begin
        gate    = rst || m_init[i] || clr[i];
        e_wr[i] = (m_cnt[i] < d) && !gate;
        e_rv[i] = (m_cnt[i] != 0 || (PAS[i] && wvalid[i])) && !gate;
        if (!e_rv[i])          erd = '0;
        else if (m_cnt[i] > 0) erd = m_dat[i][m_hd[i] % 64];
        else                   erd = wdata[i];
        chk(tg("wready", i), wready_v[i], e_wr[i]);
        chk(tg("rvalid", i), rvalid_v[i], e_rv[i]);
        chk(tg("rdata", i), rdata_a[i], erd);
        chk(tg("full", i), full_v[i], (m_cnt[i] == d));
        chk(tg("depth", i), depth_a[i], m_cnt[i]);
        chk(tg("peak", i), peak_a[i], m_pk[i]);
        chk(tg("aempty", i), ae_v[i], (m_cnt[i] <= ae));
        chk(tg("afull", i), af_v[i], (m_cnt[i] >= af));
      end
    end
  endtask

  task automatic update_model();
    for (int i = 0; i < NI; i++) begin
      bit push, pop;
      if (DEP[i] == 0) continue;
      if (rst) begin
        m_init[i] = 1; m_cnt[i] = 0; m_hd[i] = 0; m_pk[i] = 0;
      end else begin
        m_init[i] = 0;
        if (clr[i]) begin
          m_cnt[i] = 0; m_hd[i] = 0; m_pk[i] = 0;
        end else begin
          push = wvalid[i] && e_wr[i];
          pop  = e_rv[i] && rready[i];
          // popping an empty FIFO means the write went straight through
          if (!(pop && m_cnt[i] == 0)) begin
            if (pop) begin
              m_hd[i]  = (m_hd[i] + 1) % 64;
              m_cnt[i] = m_cnt[i] - 1;
            end
            if (push) begin
              m_dat[i][(m_hd[i] + m_cnt[i]) % 64] = wdata[i];
              m_cnt[i] = m_cnt[i] + 1;
            end
          end
          if (m_cnt[i] > m_pk[i]) m_pk[i] = m_cnt[i];
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    clr   = '0;
    wvalid = '0;
    rready = '0;
    for (int i = 0; i < NI; i++) begin
      wdata[i] = '0; af_th[i] = 4'd2; ae_th[i] = 4'd1;
      m_init[i] = 1; m_cnt[i] = 0; m_hd[i] = 0; m_pk[i] = 0;
    end
    af_th[0] = 4'd3;
    af_th[2] = 4'd6; ae_th[2] = 4'd2;
    @(posedge clk);
    #1;

    // Reset release with a write held pending
    wvalid[0] = 1'b1; wdata[0] = 16'h0011;
    step();
    settle();
    chk("t1_rst_wready", wready_v[0], 0);
    chk("t1_rst_rvalid", rvalid_v[0], 0);
    chk("t1_rst_rdata", rdata_a[0], 0);
    chk("t1_rst_full", full_v[0], 0);
    chk("t1_rst_depth", depth_a[0], 0);
    chk("t1_rst_peak", peak_a[0], 0);
    chk("t1_rst_aempty", ae_v[0], 1);
    chk("t1_rst_afull", af_v[0], 0);
    rst = 1'b0;
    settle();
    chk("t1_init_wready", wready_v[0], 0);
    step();
    chk("t1_wready_up", wready_v[0], 1);
    wvalid[0] = 1'b0;
    step();

    // Fill/drain the 5-deep FIFO over two laps
    for (int lap = 0; lap < 2; lap++) begin
      wvalid[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        wdata[1] = 16'(lap * 5 + k + 1);
        step();
      end
      wvalid[1] = 1'b0;
      settle();
      chk("t2_full", full_v[1], 1);
      chk("t2_depth", depth_a[1], 5);
      chk("t2_wready", wready_v[1], 0);
      rready[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        settle();
        chk("t2_rdata", rdata_a[1], lap * 5 + k + 1);
        step();
      end
      rready[1] = 1'b0;
      settle();
      chk("t2_empty", depth_a[1], 0);
    end

    // Pass-through on an empty FIFO, with and without Pass
    wvalid[0] = 1'b1; rready[0] = 1'b1; wdata[0] = 16'hBEEF;
    wvalid[5] = 1'b1; rready[5] = 1'b1; wdata[5] = 16'hBEEF;
    settle();
    chk("t3_pass_rvalid", rvalid_v[0], 1);
    chk("t3_pass_rdata", rdata_a[0], 16'hBEEF);
    chk("t3_nopass_rvalid", rvalid_v[5], 0);
    step();
    wvalid[0] = 1'b0; rready[0] = 1'b0;
    wvalid[5] = 1'b0;
    settle();
    chk("t3_pass_depth", depth_a[0], 0);
    chk("t3_pass_peak", peak_a[0], 0);
    chk("t3_nopass_rvalid2", rvalid_v[5], 1);
    chk("t3_nopass_rdata2", rdata_a[5], 16'hBEEF);
    step();
    rready[5] = 1'b0;

    // Watermarks on the 8-deep FIFO, af=6 ae=2
    wvalid[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wdata[2] = 16'h0400 + 16'(k);
      step();
      chk("t4_depth", depth_a[2], k);
      chk("t4_afull", af_v[2], (k >= 6));
      chk("t4_aempty", ae_v[2], (k <= 2));
    end
    rready[2] = 1'b1; wdata[2] = 16'h0407;
    settle();
    chk("t4_head", rdata_a[2], 16'h0401);
    step();
    wvalid[2] = 1'b0; rready[2] = 1'b0;
    settle();
    chk("t4_pp_depth", depth_a[2], 6);
    chk("t4_pp_afull", af_v[2], 1);
    chk("t4_pp_aempty", ae_v[2], 0);

    // Peak monitor and flush
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    wvalid[2] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wdata[2] = 16'h0500 + 16'(k);
      step();
    end
    wvalid[2] = 1'b0; rready[2] = 1'b1;
    repeat (4) step();
    rready[2] = 1'b0;
    settle();
    chk("t5_peak", peak_a[2], 7);
    chk("t5_depth", depth_a[2], 3);
    clr[2] = 1'b1; wvalid[2] = 1'b1;
    settle();
    chk("t5_clr_wready", wready_v[2], 0);
    chk("t5_clr_rvalid", rvalid_v[2], 0);
    step();
    clr[2] = 1'b0; wvalid[2] = 1'b0;
    settle();
    chk("t5_post_depth", depth_a[2], 0);
    chk("t5_post_peak", peak_a[2], 0);
    chk("t5_post_rvalid", rvalid_v[2], 0);

    // Random traffic on every build, including the 0- and 1-deep ones
    for (int c = 0; c < 1500; c++) begin
      int pw, pr;
      pw = 1 + (c / 250) % 3;
      pr = 1 + ((c / 250) + 1) % 3;
      if (c % 200 == 0) begin
        for (int i = 0; i < NI; i++) begin
          af_th[i] = 4'($urandom_range(0, 15));
          ae_th[i] = 4'($urandom_range(0, 15));
        end
      end
      rst = (c >= 700 && c < 702);
      for (int i = 0; i < NI; i++) begin
        wvalid[i] = ($urandom_range(0, 3) < pw);
        rready[i] = ($urandom_range(0, 3) < pr);
        wdata[i]  = 16'($urandom);
        clr[i]    = ($urandom_range(0, 63) == 0);
      end
      step();
    end
    rst = 1'b0;
    clr = '0; wvalid = '0; rready = '0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
